mips_io_bus_fabric: RTL and testbench

//  Parametrised data-bus fabric between the PPS processor data port, the SRAM data port and NUM_SLAVES IO peripherals.

---
 rtl/mips_io_bus_fabric.sv | 175 +++++++++++++++++
 tb/tb_mips_io_bus_fabric.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mips_io_bus_fabric.sv
// Data-bus fabric: zero-latency SRAM path plus a stalled, windowed IO path with
// ready handshake, timeout and a sticky first-error report.
module mips_io_bus_fabric #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_SLAVES   = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE      = 32'hFFFF0000,
  parameter int                    IO_PAGE_BITS = 16,
  parameter int                    SLAVE_SHIFT  = 8,
  parameter int                    TIMEOUT      = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            proc_addr,
  input  logic [DATA_WIDTH-1:0]            proc_wdata,
  input  logic [DATA_WIDTH/8-1:0]          proc_bwe,
  input  logic                             proc_re,
  output logic [DATA_WIDTH-1:0]            proc_rdata,
  output logic                             proc_stall,
  output logic [DATA_WIDTH/8-1:0]          mem_bwe,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [NUM_SLAVES-1:0]            io_sel,
  output logic [SLAVE_SHIFT-1:0]           io_addr,
  output logic [DATA_WIDTH-1:0]            io_wdata,
  output logic [DATA_WIDTH/8-1:0]          io_bwe,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] io_rdata,
  input  logic [NUM_SLAVES-1:0]            io_ready,
  output logic                             bus_err,
  output logic [ADDR_WIDTH-1:0]            err_addr
);
  localparam int IDX_W = IO_PAGE_BITS - SLAVE_SHIFT;
  localparam int BW    = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SLAVE_SHIFT-1:0] io_addr_q, io_addr_d;
  logic [DATA_WIDTH-1:0]  io_wdata_q, io_wdata_d;
  logic [BW-1:0]          io_bwe_q, io_bwe_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic                   bus_err_q, bus_err_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;

  logic                   io_hit, unmapped, active, stall, err_set, ready_sel;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt_inc;
  logic [ADDR_WIDTH-1:0]  err_at;
  logic [NUM_SLAVES-1:0]  slave_hit;
  logic [DATA_WIDTH-1:0]  rdata_masked [NUM_SLAVES];
  logic [DATA_WIDTH-1:0]  sel_rdata;

  assign io_hit   = proc_addr[ADDR_WIDTH-1:IO_PAGE_BITS] == IO_BASE[ADDR_WIDTH-1:IO_PAGE_BITS];
  assign idx      = proc_addr[IO_PAGE_BITS-1:SLAVE_SHIFT];
  // Extra bit keeps the compare correct when NUM_SLAVES fills the whole index range.
  assign unmapped = {1'b0, idx} >= (IDX_W + 1)'(NUM_SLAVES);
  assign active   = proc_re | (|proc_bwe);
  assign cnt_inc  = cnt_q + 1'b1;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign slave_hit[gi]    = idx_q == IDX_W'(gi);
    assign rdata_masked[gi] = slave_hit[gi] ? io_rdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel_rdata = sel_rdata | rdata_masked[i];
  end

  assign ready_sel = |(io_ready & slave_hit);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_bwe_d   = io_bwe_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    stall      = 1'b0;
    mem_bwe    = '0;
    proc_rdata = rdata_q;
    err_set    = 1'b0;
    err_at     = proc_addr;
    case (state_q)
      IDLE: begin
        if (!io_hit) begin
          mem_bwe    = proc_bwe;
          proc_rdata = mem_rdata;
        end else if (active) begin
          stall = 1'b1;
          if (unmapped) begin
            rdata_d = ERR_DATA;
            err_set = 1'b1;
            state_d = DONE;
          end else begin
            idx_d      = idx;
            io_addr_d  = proc_addr[SLAVE_SHIFT-1:0];
            io_wdata_d = proc_wdata;
            io_bwe_d   = proc_bwe;
            req_addr_d = proc_addr;
            cnt_d      = '0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (ready_sel) begin
          rdata_d  = sel_rdata;
          io_bwe_d = '0;
          state_d  = DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          rdata_d  = ERR_DATA;
          err_set  = 1'b1;
          err_at   = req_addr_q;
          io_bwe_d = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Only the first error's address is kept.
    if (err_set && !bus_err_q) begin
      bus_err_d  = 1'b1;
      err_addr_d = err_at;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_bwe_q   <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      req_addr_q <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_bwe_q   <= io_bwe_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign proc_stall = stall & ~rst;
  assign io_sel     = (state_q == REQ) ? slave_hit : '0;
  assign io_addr    = io_addr_q;
  assign io_wdata   = io_wdata_q;
  assign io_bwe     = io_bwe_q;
  assign bus_err    = bus_err_q;
  assign err_addr   = err_addr_q;
endmodule

// File: tb/tb_mips_io_bus_fabric.sv
// Directed bench for mips_io_bus_fabric: SRAM vector table plus IO handshake,
// timeout, unmapped and mid-request reset sequences.
module tb_mips_io_bus_fabric;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  proc_addr, proc_wdata, proc_rdata, mem_rdata, io_wdata, err_addr;
  logic [3:0]   proc_bwe, mem_bwe, io_sel, io_bwe, io_ready;
  logic         proc_re, proc_stall, bus_err;
  logic [7:0]   io_addr;
  logic [127:0] io_rdata;

  int total = 0;
  int bad   = 0;

  mips_io_bus_fabric dut (
    .clk(clk), .rst(rst), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_bwe(proc_bwe), .proc_re(proc_re), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_bwe(mem_bwe), .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_addr(io_addr), .io_wdata(io_wdata), .io_bwe(io_bwe),
    .io_rdata(io_rdata), .io_ready(io_ready), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bwe;
    logic        re;
    logic [31:0] mrd;
    logic [3:0]  exp_mem_bwe;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // Results of the last io_access call.
  int          a_stall, a_req, a_bwe_bad, a_mem_bad;
  logic        a_done;
  logic [3:0]  a_sel, a_sel_done;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;

  task automatic io_access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] bwe,
                           input logic re, input int slave, input int ready_at, input logic [31:0] sdata);
    io_ready = '0;
    io_rdata[slave*32 +: 32] = sdata;
    @(posedge clk); #1;
    proc_addr = addr; proc_wdata = wd; proc_bwe = bwe; proc_re = re;
    a_stall = 0; a_req = 0; a_bwe_bad = 0; a_mem_bad = 0; a_done = 1'b0;
    a_sel = '0; a_sel_done = 'x; a_addr = '0; a_wdata = '0; a_rdata = '0;
    for (int c = 0; c < 40 && !a_done; c++) begin
      @(negedge clk);
      if (mem_bwe !== 4'h0) a_mem_bad++;
      if (!proc_stall) begin
        a_done = 1'b1; a_rdata = proc_rdata; a_sel_done = io_sel;
      end else begin
        a_stall++;
        if (io_sel != 4'h0) begin
          a_req++; a_sel = io_sel; a_addr = io_addr; a_wdata = io_wdata;
          if (io_bwe !== bwe) a_bwe_bad++;
          if (a_req == ready_at) io_ready[slave] = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    check("access_completed", {63'd0, a_done}, 64'd1);
    @(posedge clk); #1;
    proc_addr = '0; proc_bwe = '0; proc_re = 1'b0; io_ready = '0;
    $display("io access addr=%h bwe=%h re=%0d stalls=%0d req_cycles=%0d rdata=%h", addr, bwe, re, a_stall, a_req, a_rdata);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 4'hF, 1'b0, 32'h1111_2222, 4'hF, 1'b1, 32'h1111_2222};
    vecs[1] = '{32'h0000_0104, 4'h0, 1'b1, 32'hCAFE_F00D, 4'h0, 1'b1, 32'hCAFE_F00D};
    vecs[2] = '{32'h0000_0200, 4'h3, 1'b0, 32'h0000_0000, 4'h3, 1'b1, 32'h0000_0000};
    vecs[3] = '{32'hFFFE_FFFC, 4'hC, 1'b1, 32'h0000_0055, 4'hC, 1'b1, 32'h0000_0055};
    vecs[4] = '{32'hFFFF_0000, 4'h0, 1'b0, 32'h0000_0077, 4'h0, 1'b0, 32'h0000_0000};

    rst = 1'b1; proc_addr = '0; proc_wdata = '0; proc_bwe = '0; proc_re = 1'b0;
    mem_rdata = '0; io_rdata = '0; io_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_io_sel", {60'd0, io_sel}, 64'd0);
    check("rst_stall", {63'd0, proc_stall}, 64'd0);
    check("rst_bus_err", {63'd0, bus_err}, 64'd0);
    check("rst_err_addr", {32'd0, err_addr}, 64'd0);
    check("rst_io_bwe", {60'd0, io_bwe}, 64'd0);
    check("rst_io_addr", {56'd0, io_addr}, 64'd0);
    check("rst_io_wdata", {32'd0, io_wdata}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      proc_addr = vecs[i].addr; proc_bwe = vecs[i].bwe; proc_re = vecs[i].re; mem_rdata = vecs[i].mrd;
      @(negedge clk);
      $display("sram vec %0d addr=%h bwe=%h re=%0d mem_bwe=%h rdata=%h stall=%0d", i, proc_addr, proc_bwe, proc_re, mem_bwe, proc_rdata, proc_stall);
      check("vec_mem_bwe", {60'd0, mem_bwe}, {60'd0, vecs[i].exp_mem_bwe});
      check("vec_stall", {63'd0, proc_stall}, 64'd0);
      check("vec_io_sel", {60'd0, io_sel}, 64'd0);
      if (vecs[i].chk_rdata) check("vec_rdata", {32'd0, proc_rdata}, {32'd0, vecs[i].exp_rdata});
    end
    @(posedge clk); #1;
    proc_addr = '0; proc_bwe = '0; proc_re = 1'b0;

    // Slave 1 load, ready in the first REQ cycle.
    io_access(32'hFFFF_0104, 32'h0, 4'h0, 1'b1, 1, 1, 32'h1234_5678);
    check("ld1_sel", {60'd0, a_sel}, 64'h2);
    check("ld1_io_addr", {56'd0, a_addr}, 64'h04);
    check("ld1_stalls", a_stall, 2);
    check("ld1_rdata", {32'd0, a_rdata}, 64'h1234_5678);
    check("ld1_done_sel", {60'd0, a_sel_done}, 64'd0);
    check("ld1_bwe", a_bwe_bad, 0);

    // Slave 3 store, ready on the fifth REQ cycle.
    io_access(32'hFFFF_0300, 32'hA5A5_A5A5, 4'hF, 1'b0, 3, 5, 32'h0);
    check("st3_sel", {60'd0, a_sel}, 64'h8);
    check("st3_req_cycles", a_req, 5);
    check("st3_stalls", a_stall, 6);
    check("st3_bwe_held", a_bwe_bad, 0);
    check("st3_mem_bwe", a_mem_bad, 0);
    check("st3_wdata", {32'd0, a_wdata}, 64'hA5A5_A5A5);
    check("st3_no_err", {63'd0, bus_err}, 64'd0);

    // Slave 2 never ready: timeout.
    io_access(32'hFFFF_0200, 32'h0, 4'h0, 1'b1, 2, 0, 32'h0);
    check("to_req_cycles", a_req, 15);
    check("to_stalls", a_stall, 16);
    check("to_rdata", {32'd0, a_rdata}, 64'hDEAD_BEEF);
    check("to_bus_err", {63'd0, bus_err}, 64'd1);
    check("to_err_addr", {32'd0, err_addr}, 64'hFFFF_0200);

    // Unmapped index 8; second error must not move err_addr.
    io_access(32'hFFFF_0800, 32'h0, 4'h0, 1'b1, 0, 0, 32'h0);
    check("um_req_cycles", a_req, 0);
    check("um_stalls", a_stall, 1);
    check("um_rdata", {32'd0, a_rdata}, 64'hDEAD_BEEF);
    check("um_bus_err", {63'd0, bus_err}, 64'd1);
    check("um_err_addr_kept", {32'd0, err_addr}, 64'hFFFF_0200);

    // Reset in the middle of a REQ.
    @(posedge clk); #1;
    proc_addr = 32'hFFFF_0010; proc_re = 1'b1; io_ready = '0;
    @(negedge clk);
    @(negedge clk);
    check("rq_sel_before_rst", {60'd0, io_sel}, 64'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rq_stall_in_rst", {63'd0, proc_stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; proc_addr = 32'h0000_0040; proc_re = 1'b0; proc_bwe = 4'h3; mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    $display("post reset sram addr=%h mem_bwe=%h rdata=%h stall=%0d io_sel=%h", proc_addr, mem_bwe, proc_rdata, proc_stall, io_sel);
    check("rq_io_sel", {60'd0, io_sel}, 64'd0);
    check("rq_stall", {63'd0, proc_stall}, 64'd0);
    check("rq_bus_err", {63'd0, bus_err}, 64'd0);
    check("rq_err_addr", {32'd0, err_addr}, 64'd0);
    check("rq_mem_bwe", {60'd0, mem_bwe}, 64'h3);
    check("rq_rdata", {32'd0, proc_rdata}, 64'h0BAD_CAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
